// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg: AES state/column types, GF(2^8) helpers and the MixColumns FSM encoding.
// With MIXCOL_INV_EN defined, the InvMixColumns multiplies are also provided.
package aes_pkg;

  localparam int NUM_COLS = 4;
  localparam int BYTE_W   = 8;
  localparam int COL_W    = 32;
  localparam int STATE_W  = 128;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul2(input byte_t x);
    return xtime(x);
  endfunction

  function automatic byte_t gf_mul3(input byte_t x);
    return xtime(x) ^ x;
  endfunction

`ifdef MIXCOL_INV_EN
  function automatic byte_t gf_mul9(input byte_t x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic byte_t gf_mulb(input byte_t x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic byte_t gf_muld(input byte_t x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic byte_t gf_mule(input byte_t x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

  // Column c occupies bits [127-32c -: 32], i.e. offset (3-c)*32 from the LSB.
  function automatic col_t col_get(input state_t s, input logic [1:0] c);
    return s[{~c, 5'b0} +: COL_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_single_column.sv
`default_nettype none
// mix_single_column: combinational MixColumns on one 32-bit column (row 0 = MSB byte).
// With MIXCOL_INV_EN, the inv input selects InvMixColumns via a shared xtime chain.
module mix_single_column
  import aes_pkg::*;
(
  input  col_t col_in,
`ifdef MIXCOL_INV_EN
  input  logic inv,
`endif
  output col_t col_out
);

  byte_t a0, a1, a2, a3;
  col_t  fwd;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign fwd = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};

`ifdef MIXCOL_INV_EN
  byte_t a  [4];
  byte_t m2 [4];
  byte_t m4 [4];
  byte_t m8 [4];
  byte_t m9 [4];
  byte_t mb [4];
  byte_t md [4];
  byte_t me [4];
  col_t  invc;

  assign a[0] = a0;
  assign a[1] = a1;
  assign a[2] = a2;
  assign a[3] = a3;

  // One 2x/4x/8x chain per byte feeds all four inverse coefficients.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
  end

  assign invc = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};

  assign col_out = inv ? invc : fwd;
`else
  assign col_out = fwd;
`endif

endmodule
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// mix_columns_seq: iterative AES MixColumns engine, COLS_PER_CYCLE columns per clock,
// valid/ready on both sides. MIXCOL_INV_EN adds in_inv to select InvMixColumns.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_bypass,
`ifdef MIXCOL_INV_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int         NCYC = NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NCYC - 1);

  mc_state_e  state;
  mc_state_e  next_state;
  state_t     work;
  logic [1:0] cnt;
  logic       inv_q;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  col_t       col_mix [COLS_PER_CYCLE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = in_bypass ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      cnt       <= '0;
      inv_q     <= 1'b0;
      out_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_state;
            cnt  <= '0;
`ifdef MIXCOL_INV_EN
            inv_q <= in_inv & ~in_bypass;
`else
            inv_q <= 1'b0;
`endif
            if (in_bypass) out_state <= in_state;
          end
        end
        RUN: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++)
            out_state[{~col_idx[g], 5'b0} +: COL_W] <= col_mix[g];
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    col_t col_sel;
    assign col_idx[g] = 2'(32'(cnt) * COLS_PER_CYCLE + g);
    assign col_sel    = col_get(work, col_idx[g]);
    mix_single_column u_mix (
      .col_in  (col_sel),
`ifdef MIXCOL_INV_EN
      .inv     (inv_q),
`endif
      .col_out (col_mix[g])
    );
  end

`ifndef MIXCOL_INV_EN
  // Forward-only build: the inverse flag is held at zero and never consulted.
  logic unused_inv;
  assign unused_inv = inv_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// tb_mix_columns_seq: randomized transactions checked against a GF(2^8) matrix model.
module tb_mix_columns_seq;

  parameter int CPC  = 1;
  localparam int NCYC = 4 / CPC;

  localparam logic [127:0] T1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] T2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] T3 = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bypass = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;
`ifdef MIXCOL_INV_EN
  logic         in_inv = 1'b0;
`endif

  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_state = '0;
  bit           exp_active = 1'b0;

  mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
`ifdef MIXCOL_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit byp, input bit inv);
    logic [7:0]   row0 [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (byp) return s;
    if (inv) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = '0;
        for (int k = 0; k < 4; k++) b = b ^ gmul(row0[(k - rr + 4) % 4], a[k]);
        r[127 - 32*c - 8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Result stability and handshake levels on every cycle the result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (!exp_active || out_state !== exp_state || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL done_cycle: out_state=%h in_ready=%b busy=%b open=%0d, expected out_state=%h in_ready=0 busy=1 open=1",
                 out_state, in_ready, busy, exp_active, exp_state);
      end
    end
  end

  task automatic accept(input logic [127:0] s, input bit byp, input bit inv);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {127'd0, in_ready}, 128'd1);
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
`ifdef MIXCOL_INV_EN
    in_inv    = inv;
`endif
    exp_state  = model(s, byp, inv);
    exp_active = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_state  = rnd128();
    in_bypass = 1'($urandom);
`ifdef MIXCOL_INV_EN
    in_inv    = 1'($urandom);
`endif
  endtask

  // Counts edges beyond the accepting one until the result appears.
  task automatic wait_result(input bit byp);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      in_state = rnd128();
      n++;
    end
    chk("latency", {96'd0, (out_valid === 1'b1) ? n : 32'hffff_ffff},
        {96'd0, byp ? 32'd0 : 32'(NCYC)});
  endtask

  task automatic hold(input int k);
    for (int i = 0; i < k; i++) begin
      in_valid = 1'($urandom);
      in_state = rnd128();
      @(negedge clk);
      chk("hold_valid", {127'd0, out_valid}, 128'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    exp_active = 1'b0;
    chk("release", {125'd0, out_valid, in_ready, busy}, {125'd0, 3'b010});
  endtask

  task automatic txn(input logic [127:0] s, input bit byp, input bit inv, input int h);
    accept(s, byp, inv);
    wait_result(byp);
    hold(h);
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, f;
    int           k;

    #1;
    chk("reset", {out_state, 3'b000}, {128'd0, 3'b000});
    chk("reset_ctl", {125'd0, out_valid, in_ready, busy}, {125'd0, 3'b010});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("model_fwd1", model(T1, 1'b0, 1'b0), R1);
    chk("model_fwd2", model(T2, 1'b0, 1'b0), R2);
    chk("model_byp",  model(T3, 1'b1, 1'b0), T3);

    txn(T1, 1'b0, 1'b0, 0);
    txn(T2, 1'b0, 1'b0, 2);
    txn(T3, 1'b1, 1'b0, 1);

    // Result held under backpressure; a waiting state is taken only once IDLE.
    accept(T2, 1'b0, 1'b0);
    wait_result(1'b0);
    hold(10);
    in_valid  = 1'b1;
    in_state  = T1;
    in_bypass = 1'b0;
`ifdef MIXCOL_INV_EN
    in_inv    = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    exp_active = 1'b0;
    chk("no_same_cycle_accept", {125'd0, out_valid, in_ready, busy}, {125'd0, 3'b010});
    exp_state  = model(T1, 1'b0, 1'b0);
    exp_active = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("second_accepted", {126'd0, in_ready, busy}, {126'd0, 2'b01});
    wait_result(1'b0);
    release_out();

    // Reset while columns are still being mixed.
    accept(rnd128(), 1'b0, 1'b0);
    k = (NCYC > 2) ? 2 : NCYC - 1;
    for (int i = 0; i < k; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_active = 1'b0;
    chk("midrun_reset_state", out_state, 128'd0);
    chk("midrun_reset_ctl", {125'd0, out_valid, in_ready, busy}, {125'd0, 3'b010});
    @(negedge clk);
    rst = 1'b0;
    txn(T1, 1'b0, 1'b0, 0);

    repeat (20) begin
      txn(rnd128(), ($urandom_range(0, 3) == 0), 1'($urandom) & 1'b0, $urandom_range(0, 3));
    end

`ifdef MIXCOL_INV_EN
    chk("model_inv1", model(R1, 1'b0, 1'b1), T1);
    txn(R1, 1'b0, 1'b1, 0);
    txn(T3, 1'b1, 1'b1, 0);
    repeat (8) begin
      s = rnd128();
      f = model(s, 1'b0, 1'b0);
      chk("model_roundtrip", model(f, 1'b0, 1'b1), s);
      txn(s, 1'b0, 1'b0, 0);
      txn(f, 1'b0, 1'b1, $urandom_range(0, 2));
    end
    repeat (10) begin
      txn(rnd128(), ($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 2));
    end
`else
    s = '0;
    f = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
